// File: rtl/nw_topic_updater.sv
// Read-modify-write controller for the word-topic count memory port.
// Handles read, saturating increment/decrement and write-swap with a fixed memory read latency.
module nw_topic_updater #(
    parameter int WORDSIZE = 32,
    parameter int ADDRSIZE = 32,
    parameter int RD_LAT   = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_req_valid,
    output logic                o_req_ready,
    input  logic [ADDRSIZE-1:0] i_req_addr,
    input  logic [1:0]          i_req_op,
    input  logic [WORDSIZE-1:0] i_req_data,
    output logic                o_resp_valid,
    output logic [WORDSIZE-1:0] o_resp_data,
    output logic                o_resp_sat,
    output logic                o_mem_wen,
    output logic [ADDRSIZE-1:0] o_mem_addr,
    output logic [WORDSIZE-1:0] o_mem_wdata,
    input  logic [WORDSIZE-1:0] i_mem_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_EXEC} state_t;

    localparam logic [1:0] LAST_CNT = 2'(RD_LAT);

    state_t              r_state, w_next;
    logic [ADDRSIZE-1:0] r_addr;
    logic [1:0]          r_op;
    logic [WORDSIZE-1:0] r_data;
    logic [WORDSIZE-1:0] r_old;
    logic [1:0]          r_cnt;
    logic [WORDSIZE-1:0] r_resp_data;
    logic                r_resp_sat;

    logic                w_accept;
    logic                w_exec;
    logic                w_cap;
    logic [WORDSIZE-1:0] w_res;
    logic [WORDSIZE-1:0] w_wdata;
    logic                w_sat;
    logic                w_wr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        o_req_ready = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_req_ready = 1'b1;
                if (i_req_valid) w_next = S_WAIT;
            end
            S_WAIT:  if (r_cnt == LAST_CNT) w_next = S_EXEC;
            S_EXEC:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    assign w_accept = (r_state == S_IDLE) && i_req_valid;
    assign w_exec   = (r_state == S_EXEC);
    assign w_cap    = (r_state == S_WAIT) && (r_cnt == LAST_CNT);

    // Saturation suppresses the write so a wrapped count never reaches memory.
    always_comb begin
        w_res   = r_old;
        w_wdata = r_old;
        w_sat   = 1'b0;
        w_wr    = 1'b0;
        case (r_op)
            2'b01: begin
                if (&r_old) w_sat = 1'b1;
                else begin
                    w_res   = r_old + WORDSIZE'(1);
                    w_wdata = r_old + WORDSIZE'(1);
                    w_wr    = 1'b1;
                end
            end
            2'b10: begin
                if (r_old == '0) w_sat = 1'b1;
                else begin
                    w_res   = r_old - WORDSIZE'(1);
                    w_wdata = r_old - WORDSIZE'(1);
                    w_wr    = 1'b1;
                end
            end
            2'b11: begin
                w_wdata = r_data;
                w_wr    = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr      <= '0;
            r_op        <= '0;
            r_data      <= '0;
            r_old       <= '0;
            r_cnt       <= '0;
            r_resp_data <= '0;
            r_resp_sat  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_addr <= i_req_addr;
                r_op   <= i_req_op;
                r_data <= i_req_data;
                r_cnt  <= '0;
            end else if (w_cap) begin
                r_old <= i_mem_rdata;
            end else if (r_state == S_WAIT) begin
                r_cnt <= r_cnt + 2'd1;
            end
            if (w_exec) begin
                r_resp_data <= w_res;
                r_resp_sat  <= w_sat;
            end
        end
    end

    // Response fields follow the live result in EXEC and hold it afterwards.
    assign o_resp_valid = w_exec;
    assign o_resp_data  = w_exec ? w_res : r_resp_data;
    assign o_resp_sat   = w_exec ? w_sat : r_resp_sat;
    assign o_mem_wen    = w_exec && w_wr;
    assign o_mem_wdata  = w_exec ? w_wdata : '0;
    assign o_mem_addr   = r_addr;

endmodule

// File: tb/tb_nw_topic_updater.sv
// Directed bench for nw_topic_updater: one instance at RD_LAT=1, one at RD_LAT=3,
// each backed by a small behavioural memory with matching read latency.
module tb_nw_topic_updater;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        v1 = 1'b0, v3 = 1'b0;
    logic [31:0] rq_addr = '0;
    logic [1:0]  rq_op = '0;
    logic [31:0] rq_data = '0;

    logic        rdy1, rv1, rs1, wen1, rdy3, rv3, rs3, wen3;
    logic [31:0] rd1, ma1, wd1, mr1, rd3, ma3, wd3, mr3;

    logic [31:0] mem1 [16];
    logic [31:0] mem3 [16];
    logic [31:0] p1, p3a, p3b, p3c;
    logic        pl_en = 1'b0, pl_sel = 1'b0;
    logic [3:0]  pl_addr = '0;
    logic [31:0] pl_data = '0;

    int total = 0;
    int bad = 0;
    int viol = 0;
    logic sel = 1'b0;

    always #5 clk = ~clk;

    nw_topic_updater #(.WORDSIZE(32), .ADDRSIZE(32), .RD_LAT(1)) u_dut1 (
        .clk(clk), .rst(rst), .i_req_valid(v1), .o_req_ready(rdy1),
        .i_req_addr(rq_addr), .i_req_op(rq_op), .i_req_data(rq_data),
        .o_resp_valid(rv1), .o_resp_data(rd1), .o_resp_sat(rs1),
        .o_mem_wen(wen1), .o_mem_addr(ma1), .o_mem_wdata(wd1), .i_mem_rdata(mr1));

    nw_topic_updater #(.WORDSIZE(32), .ADDRSIZE(32), .RD_LAT(3)) u_dut3 (
        .clk(clk), .rst(rst), .i_req_valid(v3), .o_req_ready(rdy3),
        .i_req_addr(rq_addr), .i_req_op(rq_op), .i_req_data(rq_data),
        .o_resp_valid(rv3), .o_resp_data(rd3), .o_resp_sat(rs3),
        .o_mem_wen(wen3), .o_mem_addr(ma3), .o_mem_wdata(wd3), .i_mem_rdata(mr3));

    always @(posedge clk) begin
        if (pl_en && !pl_sel) mem1[pl_addr] <= pl_data;
        else if (wen1)        mem1[ma1[3:0]] <= wd1;
        if (pl_en && pl_sel)  mem3[pl_addr] <= pl_data;
        else if (wen3)        mem3[ma3[3:0]] <= wd3;
        p1  <= mem1[ma1[3:0]];
        p3a <= mem3[ma3[3:0]];
        p3b <= p3a;
        p3c <= p3b;
    end
    assign mr1 = p1;
    assign mr3 = p3c;

    // A write must only ever coincide with a response strobe.
    always @(negedge clk) begin
        if (wen1 && !rv1) viol++;
        if (wen3 && !rv3) viol++;
    end

    wire        w_rdy = sel ? rdy3 : rdy1;
    wire        w_rv  = sel ? rv3  : rv1;
    wire        w_rs  = sel ? rs3  : rs1;
    wire        w_wen = sel ? wen3 : wen1;
    wire [31:0] w_rd  = sel ? rd3  : rd1;
    wire [31:0] w_wd  = sel ? wd3  : wd1;
    wire [31:0] w_ma  = sel ? ma3  : ma1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic s, input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_sel = s; pl_addr = a; pl_data = d;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    task automatic req(input string tag, input logic s, input logic [31:0] a, input logic [1:0] op,
                       input logic [31:0] d, input logic [31:0] ed, input logic es,
                       input int ewr, input logic [31:0] ewd);
        int lat = 0, nrv = 0, nwr = 0, nlow = 0;
        logic [31:0] gd = '0, gwd = '0, gwa = '0;
        logic gs = 1'b0;
        sel = s;
        @(negedge clk);
        rq_addr = a; rq_op = op; rq_data = d;
        if (s) v3 = 1'b1; else v1 = 1'b1;
        chk({tag, "_rdy"}, 64'(w_rdy), 64'd1);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) begin
                v1 = 1'b0; v3 = 1'b0;
                rq_data = ~d; rq_op = ~op;
            end
            if (!w_rdy) nlow++;
            if (w_rv) begin
                if (lat == 0) lat = k;
                nrv++; gd = w_rd; gs = w_rs;
            end
            if (w_wen) begin
                nwr++; gwd = w_wd; gwa = w_ma;
            end
        end
        chk({tag, "_lat"}, 64'(lat), s ? 64'd5 : 64'd3);
        chk({tag, "_nrv"}, 64'(nrv), 64'd1);
        chk({tag, "_data"}, 64'(gd), 64'(ed));
        chk({tag, "_sat"}, 64'(gs), 64'(es));
        chk({tag, "_nwr"}, 64'(nwr), 64'(ewr));
        if (ewr != 0) begin
            chk({tag, "_wdata"}, 64'(gwd), 64'(ewd));
            chk({tag, "_waddr"}, 64'(gwa), 64'(a));
        end
        chk({tag, "_busy"}, 64'(nlow), s ? 64'd5 : 64'd3);
        chk({tag, "_hold"}, 64'(w_rd), 64'(ed));
        chk({tag, "_hsat"}, 64'(w_rs), 64'(es));
    endtask

    task automatic b2b(input string tag, input logic s, input int gap);
        int n = 0;
        int ks [3];
        logic [31:0] ds [3];
        preload(s, 4'd2, 32'd0);
        sel = s;
        @(negedge clk);
        rq_addr = 32'd2; rq_op = 2'b01; rq_data = '0;
        if (s) v3 = 1'b1; else v1 = 1'b1;
        for (int k = 1; k <= 3 * gap + 2; k++) begin
            @(negedge clk);
            if (k == 2 * gap + 1) begin v1 = 1'b0; v3 = 1'b0; end
            if (w_rv) begin
                if (n < 3) begin ks[n] = k; ds[n] = w_rd; end
                n++;
            end
        end
        chk({tag, "_n"}, 64'(n), 64'd3);
        for (int j = 0; j < 3 && j < n; j++) begin
            chk({tag, "_k"}, 64'(ks[j]), 64'(j * gap + gap - 1));
            chk({tag, "_d"}, 64'(ds[j]), 64'(j + 1));
        end
        chk({tag, "_mem"}, 64'(s ? mem3[2] : mem1[2]), 64'd3);
    endtask

    initial begin
        int nrv, nwr;
        // Reset state
        #2;
        chk("rst_rv", 64'(rv1), 64'd0);
        chk("rst_wen", 64'(wen1), 64'd0);
        chk("rst_addr", 64'(ma1), 64'd0);
        chk("rst_rdata", 64'(rd1), 64'd0);
        chk("rst_wdata", 64'(wd1), 64'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_rdy", 64'(rdy1), 64'd1);
            chk("idle_wen", 64'(wen1), 64'd0);
            chk("idle_rv", 64'(rv1), 64'd0);
        end

        preload(0, 4'd5, 32'd7);
        req("inc5", 0, 32'd5, 2'b01, 32'h0, 32'd8, 1'b0, 1, 32'd8);
        chk("inc5_mem", 64'(mem1[5]), 64'd8);

        preload(0, 4'd9, 32'd0);
        req("dec0", 0, 32'd9, 2'b10, 32'h0, 32'd0, 1'b1, 0, 32'h0);
        chk("dec0_mem", 64'(mem1[9]), 64'd0);
        preload(0, 4'd9, 32'hFFFF_FFFF);
        req("incmax", 0, 32'd9, 2'b01, 32'h0, 32'hFFFF_FFFF, 1'b1, 0, 32'h0);
        chk("incmax_mem", 64'(mem1[9]), 64'hFFFF_FFFF);

        preload(0, 4'd6, 32'd5);
        req("dec5", 0, 32'd6, 2'b10, 32'h0, 32'd4, 1'b0, 1, 32'd4);

        preload(0, 4'd3, 32'h12);
        req("swap", 0, 32'd3, 2'b11, 32'hABCD, 32'h12, 1'b0, 1, 32'hABCD);
        chk("swap_mem", 64'(mem1[3]), 64'hABCD);
        req("rd3", 0, 32'd3, 2'b00, 32'h5555, 32'hABCD, 1'b0, 0, 32'h0);

        b2b("b2b1", 0, 4);
        b2b("b2b3", 1, 6);
        preload(1, 4'd7, 32'd41);
        req("inc_l3", 1, 32'd7, 2'b01, 32'h0, 32'd42, 1'b0, 1, 32'd42);

        // Reset during WAIT aborts without response or write
        preload(0, 4'd4, 32'd10);
        sel = 1'b0;
        nrv = 0; nwr = 0;
        @(negedge clk);
        rq_addr = 32'd4; rq_op = 2'b01; v1 = 1'b1;
        @(negedge clk);
        v1 = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            if (rv1) nrv++;
            if (wen1) nwr++;
            @(negedge clk);
        end
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (rv1) nrv++;
            if (wen1) nwr++;
        end
        chk("abort_rv", 64'(nrv), 64'd0);
        chk("abort_wen", 64'(nwr), 64'd0);
        chk("abort_mem", 64'(mem1[4]), 64'd10);
        chk("abort_rdy", 64'(rdy1), 64'd1);
        req("after", 0, 32'd4, 2'b01, 32'h0, 32'd11, 1'b0, 1, 32'd11);
        chk("after_mem", 64'(mem1[4]), 64'd11);

        chk("wen_outside_exec", 64'(viol), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
